// File: rtl/dmem_pkg.sv
// Shared constants for the data-RAM arbiter: port identities and arbitration modes.
package dmem_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DBG = 1'b1;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way combinational pick. On a tie the port that did not win last time is chosen,
// unless force1 hands the tie to port 1 outright.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       force1,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        if (force1 || (last_owner == OWNER_CPU)) gnt = 2'b10;
        else                                     gnt = 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the CPU load/store port and the debug/loader port onto one single-port
// data RAM; read data is steered back to the issuing port one cycle after the grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW        = 10,
  parameter int PRIO_MODE = PRIO_RR,
  parameter int MAX_WAIT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [31:0]   p0_addr,
  input  logic [31:0]   p0_wdata,
  input  logic [3:0]    p0_wstrb,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [31:0]   p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [31:0]   p1_addr,
  input  logic [31:0]   p1_wdata,
  input  logic [3:0]    p1_wstrb,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [31:0]   p1_rdata,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic           last_owner;
  logic           rd_pending;
  logic           rd_owner;
  logic [WCW-1:0] wait_cnt;

  logic       arb_last;
  logic       force1;
  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic       win_we;

  // Fixed priority reuses the round-robin pick by pinning the history to port 1,
  // which makes port 0 the tie winner; force1 is the anti-starvation override.
  assign arb_last = (PRIO_MODE == PRIO_FIXED) ? OWNER_DBG : last_owner;
  assign force1   = (PRIO_MODE == PRIO_FIXED) && (wait_cnt == WCW'(MAX_WAIT));

  rr_arb2 u_pick (
    .req        ({p1_req, p0_req}),
    .last_owner (arb_last),
    .force1     (force1),
    .gnt        (arb_gnt)
  );

  assign gnt    = rst ? 2'b00 : arb_gnt;
  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];
  assign win_we = gnt[1] ? p1_we : p0_we;

  always_comb begin
    mem_en    = |gnt;
    mem_we    = 4'h0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[1]) begin
      mem_we    = p1_we ? p1_wstrb : 4'h0;
      mem_addr  = p1_addr[AW+1:2];
      mem_wdata = p1_wdata;
    end else if (gnt[0]) begin
      mem_we    = p0_we ? p0_wstrb : 4'h0;
      mem_addr  = p0_addr[AW+1:2];
      mem_wdata = p0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner <= OWNER_DBG;
      wait_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_owner   <= OWNER_CPU;
    end else begin
      if (|gnt) last_owner <= gnt[1];
      rd_pending <= (|gnt) && !win_we;
      if ((|gnt) && !win_we) rd_owner <= gnt[1];
      if (!p1_req || gnt[1])             wait_cnt <= '0;
      else if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Masking with rst drops a read that was granted just before reset.
  assign p0_rvalid = rd_pending && (rd_owner == OWNER_CPU) && !rst;
  assign p1_rvalid = rd_pending && (rd_owner == OWNER_DBG) && !rst;
  assign p0_rdata  = p0_rvalid ? mem_rdata : 32'h0;
  assign p1_rdata  = p1_rvalid ? mem_rdata : 32'h0;

  // Byte-offset and out-of-range address bits carry no meaning for a word RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p0_addr[31:AW+2], p0_addr[1:0], p1_addr[31:AW+2], p1_addr[1:0]};

endmodule
